// File: rtl/codifica_hamming_serial.sv
// Hamming(15,11) encoder with framed serial transmitter (start, 15 bits LSB-first, stop).
// Optional macro HAMMING_ERR_INJECT_EN adds erro_pos to flip one transmitted codeword bit.
module codifica_hamming_serial #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] dado,
    input  logic        dado_valid,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [3:0]  erro_pos,
`endif
    output logic        dado_ready,
    output logic        tx,
    output logic [14:0] palavra,
    output logic        ocupado,
    output logic        fim
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST  = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DADOS,
        PARADA
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic [14:0] shift_q, shift_d;
    logic [14:0] palavra_q, palavra_d;

    logic [14:0] codeword;
    logic [14:0] tx_word;
    logic        baud_done;

    // Index i carries Hamming position i+1; parity bits sit at positions 1, 2, 4 and 8.
    assign codeword[2]  = dado[0];
    assign codeword[4]  = dado[1];
    assign codeword[5]  = dado[2];
    assign codeword[6]  = dado[3];
    assign codeword[8]  = dado[4];
    assign codeword[9]  = dado[5];
    assign codeword[10] = dado[6];
    assign codeword[11] = dado[7];
    assign codeword[12] = dado[8];
    assign codeword[13] = dado[9];
    assign codeword[14] = dado[10];
    assign codeword[0]  = ^{codeword[2], codeword[4], codeword[6], codeword[8],
                            codeword[10], codeword[12], codeword[14]};
    assign codeword[1]  = ^{codeword[2], codeword[5], codeword[6], codeword[9],
                            codeword[10], codeword[13], codeword[14]};
    assign codeword[3]  = ^{codeword[4], codeword[5], codeword[6], codeword[11],
                            codeword[12], codeword[13], codeword[14]};
    assign codeword[7]  = ^{codeword[8], codeword[9], codeword[10], codeword[11],
                            codeword[12], codeword[13], codeword[14]};

`ifdef HAMMING_ERR_INJECT_EN
    // Only the transmitted copy is corrupted; palavra keeps the clean codeword.
    logic [14:0] err_mask;
    always_comb begin
        err_mask = '0;
        if (erro_pos != 4'd0) begin
            err_mask = 15'd1 << (erro_pos - 4'd1);
        end
    end
    assign tx_word = codeword ^ err_mask;
`else
    assign tx_word = codeword;
`endif

    assign baud_done = (baud_q == BAUD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            palavra_q <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            palavra_q <= palavra_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        palavra_d = palavra_q;
        tx        = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (dado_valid) begin
                    state_d   = START;
                    palavra_d = codeword;
                    shift_d   = tx_word;
                    baud_d    = '0;
                    bit_d     = '0;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_done) begin
                    state_d = DADOS;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            DADOS: begin
                tx = shift_q[0];
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = PARADA;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = {1'b0, shift_q[14:1]};
                    end
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            PARADA: begin
                if (baud_done) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign dado_ready = (state_q == IDLE);
    assign ocupado    = (state_q != IDLE);
    assign fim        = (state_q == PARADA) && baud_done;
    assign palavra    = palavra_q;

endmodule

// File: tb/tb_codifica_hamming_serial.sv
// Self-checking bench: behavioural frame model compared every cycle, plus directed literals.
module tb_codifica_hamming_serial;

    localparam int CPB = 4;
    localparam int FRAME = 17 * CPB;

    logic        clk;
    logic        rst_n;
    logic [10:0] dado;
    logic        dado_valid;
    logic [3:0]  erro_pos;
    logic        dado_ready;
    logic        tx;
    logic [14:0] palavra;
    logic        ocupado;
    logic        fim;

    int n_checks;
    int n_errors;

    codifica_hamming_serial #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dado       (dado),
        .dado_valid (dado_valid),
`ifdef HAMMING_ERR_INJECT_EN
        .erro_pos   (erro_pos),
`endif
        .dado_ready (dado_ready),
        .tx         (tx),
        .palavra    (palavra),
        .ocupado    (ocupado),
        .fim        (fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Hamming rule: data fills non-power-of-two positions in order; parity p covers positions with bit p set.
    function automatic logic [14:0] model_cw(input logic [10:0] d);
        logic [14:0] w;
        int k;
        w = '0;
        k = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos <= 15; pos++) begin
                if (((pos & p) != 0) && (pos != p)) par = par ^ w[pos-1];
            end
            w[p-1] = par;
        end
        return w;
    endfunction

    typedef struct packed {
        logic tx;
        logic fim;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [14:0] palavra_exp;

    // Model: a frame is a list of expected per-cycle outputs; an empty list means idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            palavra_exp <= '0;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (dado_valid) begin
            logic [14:0] cw;
            logic [14:0] sent;
            cw   = model_cw(dado);
            sent = cw;
`ifdef HAMMING_ERR_INJECT_EN
            if (erro_pos != 0) sent[erro_pos-1] = ~sent[erro_pos-1];
`endif
            palavra_exp <= cw;
            for (int k = 0; k < FRAME; k++) begin
                cyc_t c;
                int b;
                b = k / CPB;
                c.tx  = (b == 0) ? 1'b0 : (b == 16) ? 1'b1 : sent[b-1];
                c.fim = (k == FRAME - 1);
                exp_q.push_back(c);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                check("tx", tx, 1);
                check("dado_ready", dado_ready, 1);
                check("ocupado", ocupado, 0);
                check("fim", fim, 0);
            end else begin
                check("tx", tx, exp_q[0].tx);
                check("dado_ready", dado_ready, 0);
                check("ocupado", ocupado, 1);
                check("fim", fim, exp_q[0].fim);
            end
            check("palavra", palavra, palavra_exp);
        end
    end

    // Offers a word until it is accepted; returns just after the transfer edge.
    task automatic send(input logic [10:0] w, input logic [3:0] ep, input bit hold, output int cyc);
        bit ok;
        ok         = 1'b0;
        cyc        = 0;
        dado       = w;
        erro_pos   = ep;
        dado_valid = 1'b1;
        while (!ok && cyc < 3 * FRAME) begin
            @(negedge clk);
            ok = dado_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("xfer_done", ok, 1);
        if (!hold) dado_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!dado_ready && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", dado_ready, 1);
    endtask

    initial begin
        int cyc;
        int n;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        dado       = '0;
        dado_valid = 1'b0;
        erro_pos   = '0;

        #2;
        check("rst_tx", tx, 1);
        check("rst_ready", dado_ready, 1);
        check("rst_ocupado", ocupado, 0);
        check("rst_fim", fim, 0);
        check("rst_palavra", palavra, 15'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero word; fim on the last cycle of a 17-bit frame.
        send(11'h000, 4'd0, 1'b0, cyc);
        check("palavra_000", palavra, 15'h0000);
        n = 0;
        @(negedge clk);
        while (!fim && n < 2 * FRAME) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("fim_cycle", n, FRAME - 1);

        // All-ones word.
        wait_idle();
        send(11'h7FF, 4'd0, 1'b0, cyc);
        check("palavra_7ff", palavra, 15'h7FFF);
        repeat (CPB) @(posedge clk);
        @(negedge clk);
        check("bit0_7ff", tx, 1);

        // Back-to-back with dado_valid held; a busy-time pulse of another word is ignored.
        wait_idle();
        send(11'h001, 4'd0, 1'b1, cyc);
        check("palavra_001", palavra, 15'h0007);
        dado = 11'h010;
        send(11'h010, 4'd0, 1'b0, cyc);
        check("b2b_gap", cyc, FRAME + 1);
        check("palavra_010", palavra, 15'h0181);
        repeat (3) @(posedge clk);
        #1;
        dado       = 11'h555;
        dado_valid = 1'b1;
        @(posedge clk);
        #1;
        dado_valid = 1'b0;
        check("busy_ignored", palavra, 15'h0181);

        // Reset in the middle of the data bits.
        wait_idle();
        send(11'h001, 4'd0, 1'b0, cyc);
        repeat (6 * CPB) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_ready", dado_ready, 1);
        check("abort_ocupado", ocupado, 0);
        check("abort_fim", fim, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(11'h010, 4'd0, 1'b0, cyc);
        check("post_abort_palavra", palavra, 15'h0181);

`ifdef HAMMING_ERR_INJECT_EN
        wait_idle();
        send(11'h000, 4'd5, 1'b0, cyc);
        check("inj_palavra", palavra, 15'h0000);
        repeat (5 * CPB) @(posedge clk);
        @(negedge clk);
        check("inj_bit4", tx, 1);
`endif

        // Randomised traffic.
        wait_idle();
        for (int i = 0; i < 40; i++) begin
            logic [10:0] w;
            logic [3:0]  ep;
            bit          hold;
            w    = 11'($urandom);
            ep   = 4'd0;
`ifdef HAMMING_ERR_INJECT_EN
            ep   = 4'($urandom_range(0, 15));
`endif
            hold = 1'($urandom_range(0, 1));
            send(w, ep, hold, cyc);
            check("rand_palavra", palavra, model_cw(w));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
                dado       = 11'($urandom);
                erro_pos   = 4'($urandom);
                dado_valid = 1'b1;
                @(posedge clk);
                #1;
                dado_valid = 1'b0;
            end
            if (!hold) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        dado_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
